// File: rtl/servo_pwm.sv
// servo_pwm: 50 Hz hobby-servo pulse generator with angle-step and frame debug clocks
module servo_pwm #(
  parameter int FRAME_CYCLES = 2_000_000,
  parameter int MIN_CYCLES   = 100_000,
  parameter int STEP_CYCLES  = 556,
  parameter int MAX_ANGLE    = 180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dutty,
  output logic       CLKOUT,
  output logic       CLKOUT2,
  output logic       PWM
);
  localparam int MAX_WIDTH = MIN_CYCLES + MAX_ANGLE * STEP_CYCLES;
  localparam int CW = $clog2(FRAME_CYCLES) > 21 ? $clog2(FRAME_CYCLES) : 21;
  localparam int WW = $clog2(MAX_WIDTH + 1) > 18 ? $clog2(MAX_WIDTH + 1) : 18;
  localparam int HALF_STEP = STEP_CYCLES / 2;
  localparam int SW = $clog2(HALF_STEP) > 1 ? $clog2(HALF_STEP) : 1;
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] FRAME_HALF = CW'(FRAME_CYCLES / 2);
  localparam logic [SW-1:0] STEP_LAST  = SW'(HALF_STEP - 1);
  localparam logic [7:0]    ANGLE_MAX  = 8'(MAX_ANGLE);

  logic [CW-1:0] frame_q, frame_d;
  logic [SW-1:0] step_q, step_d;
  logic [WW-1:0] width_q, width_d, new_width;
  logic [7:0]    angle;
  logic          frame_start;
  logic          pwm_q, pwm_d;
  logic          clkout_q, clkout_d;
  logic          clkout2_q, clkout2_d;

  // Frame position 0 is the frame start: the angle is latched there so mid-frame changes cannot glitch the pulse
  always_comb begin
    frame_start = frame_q == '0;
    angle       = dutty > ANGLE_MAX ? ANGLE_MAX : dutty;
    new_width   = WW'(MIN_CYCLES + int'(angle) * STEP_CYCLES);
    frame_d     = frame_q == FRAME_LAST ? '0 : frame_q + CW'(1);
    width_d     = frame_start ? new_width : width_q;
    pwm_d       = frame_start ? 1'b1 : frame_q < CW'(width_q);
    clkout2_d   = frame_q < FRAME_HALF;
    step_d      = step_q == STEP_LAST ? '0 : step_q + SW'(1);
    clkout_d    = step_q == STEP_LAST ? ~clkout_q : clkout_q;
  end

  // All state and outputs are registered; reset forces a fresh frame on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q   <= '0;
      step_q    <= '0;
      width_q   <= WW'(MIN_CYCLES);
      pwm_q     <= 1'b0;
      clkout_q  <= 1'b0;
      clkout2_q <= 1'b0;
    end else begin
      frame_q   <= frame_d;
      step_q    <= step_d;
      width_q   <= width_d;
      pwm_q     <= pwm_d;
      clkout_q  <= clkout_d;
      clkout2_q <= clkout2_d;
    end
  end

  assign PWM     = pwm_q;
  assign CLKOUT  = clkout_q;
  assign CLKOUT2 = clkout2_q;
endmodule

// File: tb/tb_servo_pwm.sv
// tb_servo_pwm: randomized scoreboard bench for servo_pwm using scaled-down timing parameters
module tb_servo_pwm;
  localparam int FRAME = 2000;
  localparam int MINW  = 100;
  localparam int STEP  = 10;
  localparam int MAXA  = 180;
  localparam int HALF  = STEP / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] dutty = 8'd0;
  logic       CLKOUT, CLKOUT2, PWM;
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int dir[6] = '{90, 180, 255, 179, 181, 1};

  servo_pwm #(.FRAME_CYCLES(FRAME), .MIN_CYCLES(MINW), .STEP_CYCLES(STEP), .MAX_ANGLE(MAXA)) dut (
    .clk(clk), .rst_n(rst_n), .dutty(dutty), .CLKOUT(CLKOUT), .CLKOUT2(CLKOUT2), .PWM(PWM)
  );

  always #5 clk = ~clk;

  function automatic int width_of(int a);
    return MINW + (a > MAXA ? MAXA : a) * STEP;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_frame(int v);
    dutty = 8'(v);
    exp_q.push_back(width_of(v));
  endtask

  task automatic glitch_wait(int n);
    repeat (n) begin
      @(negedge clk);
      if ($urandom_range(0, 63) == 0) dutty = 8'($urandom_range(0, 255));
    end
  endtask

  int   tick = 0, last_rise = -1, pw_run = 0, ck_run = 0, c2_run = 0;
  logic p_prev = 1'b0, ck_prev = 1'b0, c2_prev = 1'b0;
  bit   ck_seen = 1'b0, c2_seen = 1'b0;

  always @(negedge clk) begin
    tick++;
    if (!rst_n) begin
      pw_run = 0; ck_run = 0; c2_run = 0; last_rise = -1;
      p_prev = 1'b0; ck_prev = 1'b0; c2_prev = 1'b0;
      ck_seen = 1'b0; c2_seen = 1'b0;
    end else begin
      if (PWM && !p_prev) begin
        chk("clkout2_with_pwm", int'(CLKOUT2 && !c2_prev), 1);
        if (last_rise >= 0) chk("pwm_period", tick - last_rise, FRAME);
        last_rise = tick;
      end
      if (PWM) pw_run++;
      else if (p_prev) begin
        if (exp_q.size() == 0) chk("pwm_unexpected", pw_run, 0);
        else chk("pwm_width", pw_run, exp_q.pop_front());
        pw_run = 0;
      end
      if (CLKOUT !== ck_prev) begin
        if (ck_seen) chk("clkout_half", ck_run, HALF);
        ck_seen = 1'b1;
        ck_run = 1;
      end else ck_run++;
      if (CLKOUT2 !== c2_prev) begin
        if (c2_seen) chk(c2_prev ? "clkout2_high" : "clkout2_low", c2_run, c2_prev ? FRAME / 2 : FRAME - FRAME / 2);
        c2_seen = 1'b1;
        c2_run = 1;
      end else c2_run++;
      p_prev = PWM; ck_prev = CLKOUT; c2_prev = CLKOUT2;
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_async_pwm", PWM, 0);
    chk("rst_async_clkout", CLKOUT, 0);
    chk("rst_async_clkout2", CLKOUT2, 0);
    repeat (10) @(negedge clk);
    chk("rst_hold_pwm", PWM, 0);
    chk("rst_hold_clkout", CLKOUT, 0);
    chk("rst_hold_clkout2", CLKOUT2, 0);
    start_frame(0);
    rst_n = 1'b1;
    glitch_wait(1);
    chk("pwm_first_edge", PWM, 1);
    chk("clkout2_first_edge", CLKOUT2, 1);
    chk("clkout_first_edge", CLKOUT, 0);
    glitch_wait(FRAME - 1);
    for (int f = 0; f < 10; f++) begin
      start_frame(f < 6 ? dir[f] : int'($urandom_range(0, 255)));
      glitch_wait(FRAME);
    end
    start_frame(int'($urandom_range(0, 255)));
    glitch_wait(50);
    chk("pwm_before_reset", PWM, 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_pwm", PWM, 0);
    chk("rst_mid_clkout2", CLKOUT2, 0);
    chk("rst_mid_clkout", CLKOUT, 0);
    repeat (3) @(negedge clk);
    start_frame(90);
    rst_n = 1'b1;
    glitch_wait(1);
    chk("pwm_after_reset", PWM, 1);
    glitch_wait(FRAME - 1);
    start_frame(255);
    glitch_wait(width_of(255) + 20);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
